// File: rtl/regfile_wb.sv
// Architectural register file for the miniRV write-back path: two combinational read ports, one write port.
// Optional retirement trace outputs are built when REGFILE_TRACE_EN is defined.
module regfile_wb #(
  parameter int unsigned          DATA_W   = 32,
  parameter int unsigned          ADDR_W   = 5,
  parameter bit                   BYPASS   = 1'b1,
  parameter logic [DATA_W-1:0]    SP_RESET = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wR,
  input  logic [DATA_W-1:0] wD,
  input  logic [DATA_W-1:0] wb_pc,
  input  logic [ADDR_W-1:0] rR1,
  input  logic [ADDR_W-1:0] rR2,
  output logic [DATA_W-1:0] rD1,
  output logic [DATA_W-1:0] rD2
`ifdef REGFILE_TRACE_EN
  ,
  output logic              debug_wb_have_inst,
  output logic [DATA_W-1:0] debug_wb_pc,
  output logic              debug_wb_ena,
  output logic [ADDR_W-1:0] debug_wb_reg,
  output logic [DATA_W-1:0] debug_wb_value
`endif
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic              wr_en;

  assign wr_en = we && (wR != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i[ADDR_W-1:0]] <= (i == 32'd2) ? SP_RESET : '0;
      end
    end else if (wr_en) begin
      regs[wR] <= wD;
    end
  end

  // Priority: x0 forces zero over the write-first bypass, which overrides stored data.
  always_comb begin
    rD1 = regs[rR1];
    if (BYPASS && wr_en && (wR == rR1)) rD1 = wD;
    if (rR1 == '0) rD1 = '0;
  end

  always_comb begin
    rD2 = regs[rR2];
    if (BYPASS && wr_en && (wR == rR2)) rD2 = wD;
    if (rR2 == '0) rD2 = '0;
  end

`ifdef REGFILE_TRACE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      debug_wb_have_inst <= 1'b0;
      debug_wb_pc        <= '0;
      debug_wb_ena       <= 1'b0;
      debug_wb_reg       <= '0;
      debug_wb_value     <= '0;
    end else begin
      debug_wb_have_inst <= 1'b1;
      debug_wb_pc        <= wb_pc;
      debug_wb_ena       <= wr_en;
      debug_wb_reg       <= wR;
      debug_wb_value     <= wD;
    end
  end
`else
  logic unused_wb_pc;
  always_comb unused_wb_pc = ^wb_pc;
`endif

endmodule
